// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies and FSM state type.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } muldiv_state_e;

  // True for the multi-cycle multiply operations.
  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // True for the multi-cycle divide operations.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_alu.sv
// Combinational 64-bit multiply/divide datapath working on latched operands.
module muldiv_alu
  import muldiv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  // Signed division with the divisor -1 handled by negation, which gives the
  // architecturally wrapped 0x80000000 for INT_MIN / -1 without relying on
  // the overflow behaviour of the divide operator.
  function automatic logic [63:0] div_signed(input logic [31:0] n, input logic [31:0] d);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (d == 32'hFFFF_FFFF) begin
      q = 32'sd0 - $signed(n);
      r = 32'sd0;
    end else begin
      q = $signed(n) / $signed(d);
      r = $signed(n) % $signed(d);
    end
    return {r, q};
  endfunction

  // Form all candidate results, then select by the latched operation.
  always_comb begin
    div0   = (b == 32'd0);
    div_b  = div0 ? 32'd1 : b;
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    {rem_s, quo_s} = div_signed(a, div_b);
    quo_u  = a / div_b;
    rem_u  = a % div_b;
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      OP_MULT:  begin hi_res = prod_s[63:32]; lo_res = prod_s[31:0]; end
      OP_MULTU: begin hi_res = prod_u[63:32]; lo_res = prod_u[31:0]; end
      OP_DIV:   begin hi_res = rem_s;         lo_res = quo_s;        end
      OP_DIVU:  begin hi_res = rem_u;         lo_res = quo_u;        end
      default:  begin hi_res = 32'd0;         lo_res = 32'd0;        end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide control: IDLE/RUN FSM, latency counter, operand latches and
// the architectural HI/LO registers.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  muldiv_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;

  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        div0;

  muldiv_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  // Next-state logic: launch in IDLE, count down in RUN, commit on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (is_mul_op(Op) || is_div_op(Op)) begin
            op_d    = Op;
            a_d     = A;
            b_d     = B;
            cnt_d   = is_mul_op(Op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_d = ST_RUN;
          end else if (Op == OP_MTHI) begin
            hi_d = A;
          end else if (Op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          // A zero divisor keeps the old HI/LO but still takes full latency.
          if (!(is_div_op(op_q) && div0)) begin
            hi_d = hi_res;
            lo_d = lo_res;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State, counter, operand latches and HI/LO with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: arithmetic reference model plus
// directed vectors with hand-computed results.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int failures;
  bit cmp_en;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns {skip_write, hi, lo} using 64-bit integers.
  function automatic logic [64:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [64:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (op)
      OP_MULT:  r = {1'b0, sa * sb};
      OP_MULTU: r = {1'b0, ua * ub};
      OP_DIV: begin
        if (b == 32'd0) r = {1'b1, 64'd0};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {1'b0, sr[31:0], sq[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) r = {1'b1, 64'd0};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {1'b0, ur[31:0], uq[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Reference behaviour: remaining busy cycles, pending result, HI/LO.
  int          m_left;
  logic [64:0] p_res;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      p_res  <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && !p_res[64]) begin
        m_hi <= p_res[63:32];
        m_lo <= p_res[31:0];
      end
    end else if (Start) begin
      if (Op == OP_MULT || Op == OP_MULTU) begin
        p_res  <= calc(Op, A, B);
        m_left <= MC;
      end else if (Op == OP_DIV || Op == OP_DIVU) begin
        p_res  <= calc(Op, A, B);
        m_left <= DC;
      end else if (Op == OP_MTHI) begin
        m_hi <= A;
      end else if (Op == OP_MTLO) begin
        m_lo <= A;
      end
    end
  end

  // Per-cycle comparison of DUT against the reference.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("cyc_busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
      check("cyc_hi", HI, m_hi);
      check("cyc_lo", LO, m_lo);
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit poke);
    int n;
    n = 0;
    @(negedge clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom;
    while (Busy && n < 100) begin
      n++;
      if (poke && n == 2) begin
        Start = 1'b1; Op = OP_MTLO; A = 32'd9;
      end else begin
        Start = 1'b0; A = $urandom;
      end
      B = $urandom;
      @(negedge clk);
    end
    Start = 1'b0;
    check({name, "_cycles"}, n, exp_cyc);
    check({name, "_hi"}, HI, exp_hi);
    check({name, "_lo"}, LO, exp_lo);
  endtask

  task automatic one_cycle(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    Start = 1'b1; Op = op; A = a;
    @(negedge clk);
    Start = 1'b0; A = $urandom;
    check({name, "_busy"}, {31'd0, Busy}, 32'd0);
    check({name, "_hi"}, HI, exp_hi);
    check({name, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    checks = 0; failures = 0; cmp_en = 1'b0;
    reset = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, DC, 32'd2, 32'd14, 1'b0);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    one_cycle("mthi11", OP_MTHI, 32'h11, 32'h11, 32'hFFFF_FFFD);
    one_cycle("mtlo22", OP_MTLO, 32'h22, 32'h11, 32'h22);
    run_op("div0", OP_DIV, 32'd5, 32'd0, DC, 32'h11, 32'h22, 1'b0);
    one_cycle("undef6", 3'd6, 32'h55, 32'h11, 32'h22);
    one_cycle("undef7", 3'd7, 32'h66, 32'h11, 32'h22);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000, 1'b0);
    run_op("multu_poke", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'd1, 1'b1);
    one_cycle("mthi_abcd", OP_MTHI, 32'hABCD, 32'hABCD, 32'd1);
    run_op("mult_after_mthi", OP_MULT, 32'h1_0000, 32'h1_0000, MC, 32'd1, 32'd0, 1'b0);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, DC, 32'hF, 32'h0FFF_FFFF, 1'b0);
    run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, DC, 32'd1, 32'hFFFF_FFFD, 1'b0);

    // Abort a divide mid-flight with an asynchronous reset.
    @(negedge clk);
    Start = 1'b1; Op = OP_DIV; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'd0, Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("mult_after_rst", OP_MULT, 32'd3, 32'd4, MC, 32'd0, 32'd12, 1'b0);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  E-stage multiply/divide or HI/LO-write request, single-cycle pulse.
REQ-006 SHALL have port Op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port A  input  32  rs operand, forwarded value.
REQ-008 SHALL have port B  input  32  rt operand, forwarded value.
REQ-009 SHALL have port Busy  output  1  operation in progress; consumed by the hazard unit as Busy.
REQ-010 SHALL have port HI  output  32  HI register.
REQ-011 SHALL have port LO  output  32  LO register.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; Busy = (state == RUN), registered.
REQ-013 In IDLE, Start with Op in {MULT, MULTU, DIV, DIVU} SHALL latch A, B and Op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-014 In RUN, the counter SHALL decrement each cycle; at the edge where counter == 1, HI/LO SHALL be written and the FSM SHALL return to IDLE.
REQ-015 Busy SHALL be high for exactly MULT_CYCLES or DIV_CYCLES cycles after the Start edge, and the new HI/LO SHALL be visible in the first cycle Busy is low.
REQ-016 MULT/MULTU SHALL form the 64-bit signed/unsigned product: HI = [63:32], LO = [31:0].
REQ-017 DIV SHALL compute signed quotient to LO and remainder to HI, truncating toward zero with remainder sign = dividend sign; DIVU SHALL compute the unsigned equivalent.
REQ-018 A divide with latched B == 0 SHALL complete with full DIV_CYCLES timing and leave HI/LO unchanged.
REQ-019 DIV with 0x80000000 / 0xFFFFFFFF SHALL produce LO = 0x80000000, HI = 0.
REQ-020 In IDLE, Start with MTHI SHALL write HI = A (MTLO: LO = A) on that edge; Busy SHALL stay 0.
REQ-021 Start while in RUN SHALL be ignored: no relaunch, no HI/LO write, no change to latched operands.
REQ-022 Undefined Op encodings with Start SHALL be ignored.
REQ-023 HI/LO SHALL change only per REQ-014 and REQ-020; the outputs are direct register outputs with no combinational path from inputs.
REQ-024 Operands SHALL be taken only from the latched copies; changes on A/B during RUN SHALL have no effect.

Reset
REQ-025 reset SHALL asynchronously force state = IDLE, counter = 0, Busy = 0, HI = 0, LO = 0, latched operands = 0.
REQ-026 reset asserted during RUN SHALL abort the operation with no HI/LO write; the first Start after release SHALL behave as from IDLE.

Structure
REQ-027 Op encodings (3-bit) and default cycle constants SHALL live in a shared package used by muldiv_ctrl, the decoder and the hazard unit.
REQ-028 The 64-bit arithmetic SHALL sit in one combinational sub-module, muldiv_alu (inputs: latched op/A/B; outputs: hi_res, lo_res, div0); the FSM, counter and HI/LO registers SHALL stay in muldiv_ctrl.

Verification
REQ-029 MULT A=0xFFFFFFFE(-2), B=3 -> Busy high 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
REQ-030 DIVU A=100, B=7 -> Busy high 10 cycles; then LO = 14, HI = 2; DIV A=-7, B=2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-031 DIV A=5, B=0 with prior HI=0x11, LO=0x22 -> Busy 10 cycles; HI/LO stay 0x11/0x22.
REQ-032 MULTU 0xFFFFFFFF*0xFFFFFFFF, second Start (MTLO A=9) at cycle 2 -> second Start ignored; HI = 0xFFFFFFFE, LO = 1.
REQ-033 MTHI A=0xABCD in IDLE -> HI = 0xABCD next cycle, Busy never high; same-cycle MULT afterwards sees updated HI overwritten on completion.
REQ-034 DIV started, reset at cycle 4 -> Busy = 0 and HI = LO = 0 immediately; new MULT 3*4 after release -> LO = 12 after 5 cycles.
